// File: rtl/glyph_pkg.sv
// -----------------------------------------------------------------------------
// glyph_pkg
// Shared types and constants for the character-cell renderer.
//   color_idx_t : 3-bit colour index returned by the font ROM
//   COORD_W     : width of screen coordinates and window offsets
//   PAL_*       : fixed palette colours for indices 2..7
// -----------------------------------------------------------------------------
package glyph_pkg;

    localparam int COORD_W = 10;

    typedef logic [2:0] color_idx_t;

    localparam logic [23:0] PAL_RED    = 24'hFF0000;
    localparam logic [23:0] PAL_GREEN  = 24'h00FF00;
    localparam logic [23:0] PAL_BLUE   = 24'h0000FF;
    localparam logic [23:0] PAL_YELLOW = 24'hFFFF00;
    localparam logic [23:0] PAL_CYAN   = 24'h00FFFF;
    localparam logic [23:0] PAL_WHITE  = 24'hFFFFFF;

endpackage

// File: rtl/glyph_palette.sv
// -----------------------------------------------------------------------------
// glyph_palette
// Combinational colour-index to RGB decoder.
//   i_idx    : colour index from the font ROM
//   i_fg_rgb : colour for index 1
//   i_bg_rgb : colour for index 0
//   o_rgb    : decoded 24-bit colour (indices 2..7 are fixed colours)
// -----------------------------------------------------------------------------
module glyph_palette
    import glyph_pkg::*;
(
    input  color_idx_t  i_idx,
    input  logic [23:0] i_fg_rgb,
    input  logic [23:0] i_bg_rgb,
    output logic [23:0] o_rgb
);

    always_comb begin
        o_rgb = i_bg_rgb;
        case (i_idx)
            3'd0:    o_rgb = i_bg_rgb;
            3'd1:    o_rgb = i_fg_rgb;
            3'd2:    o_rgb = PAL_RED;
            3'd3:    o_rgb = PAL_GREEN;
            3'd4:    o_rgb = PAL_BLUE;
            3'd5:    o_rgb = PAL_YELLOW;
            3'd6:    o_rgb = PAL_CYAN;
            default: o_rgb = PAL_WHITE;
        endcase
    end

endmodule

// File: rtl/glyph_renderer.sv
// -----------------------------------------------------------------------------
// glyph_renderer
// Draws one glyph from a shared font ROM at a programmable origin, with
// optional 2^SCALE_LOG2 magnification. Pixel sampled at edge t is visible on
// RGB/rgb_valid/in_glyph after edge t+LAT (LAT = ROM_LAT+2); rom_addr for it
// is visible after edge t+1.
//
// Ports:
//   clk, rst            : pixel clock, synchronous active-high reset
//   pix_valid           : current coordinates are an active-area pixel
//   frame_start         : one-cycle pulse per frame (blink timing only)
//   char                : character code
//   fg_rgb / bg_rgb     : colours for ROM index 1 / 0
//   initialX / initialY : glyph origin
//   currentX / currentY : scan position
//   rom_addr            : registered font ROM address
//   rom_q               : colour index from the ROM, ROM_LAT cycles later
//   RGB                 : pixel colour (0 outside the window or when invalid)
//   rgb_valid, in_glyph : pix_valid / window flag aligned to RGB
//
// Build option: define GLYPH_BLINK_EN to make char[7] a blink attribute;
// otherwise the full 8-bit code is used and frame_start is ignored.
// -----------------------------------------------------------------------------
module glyph_renderer
    import glyph_pkg::*;
#(
    parameter  int GLYPH_W      = 8,
    parameter  int GLYPH_H      = 16,
    parameter  int SCALE_LOG2   = 0,
    parameter  int CHAR_MIN     = 32,
    parameter  int CHAR_MAX     = 126,
    parameter  int SUBST_CHAR   = 63,
    parameter  int ROM_LAT      = 1,
    parameter  int BLINK_FRAMES = 30,
    localparam int ADDR_W       = $clog2((CHAR_MAX - CHAR_MIN + 1) * GLYPH_W * GLYPH_H),
    localparam int LAT          = ROM_LAT + 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pix_valid,
    input  logic                frame_start,
    input  logic [7:0]          char,
    input  logic [23:0]         fg_rgb,
    input  logic [23:0]         bg_rgb,
    input  logic [COORD_W-1:0]  initialX,
    input  logic [COORD_W-1:0]  initialY,
    input  logic [COORD_W-1:0]  currentX,
    input  logic [COORD_W-1:0]  currentY,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [2:0]          rom_q,
    output logic [23:0]         RGB,
    output logic                rgb_valid,
    output logic                in_glyph
);

    localparam int NUM_CHARS = CHAR_MAX - CHAR_MIN + 1;
    localparam int IDX_W     = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
    localparam int CELL      = GLYPH_W * GLYPH_H;

    localparam logic [COORD_W:0]  WIN_W     = (COORD_W + 1)'(GLYPH_W << SCALE_LOG2);
    localparam logic [COORD_W:0]  WIN_H     = (COORD_W + 1)'(GLYPH_H << SCALE_LOG2);
    localparam logic [7:0]        CODE_MIN  = 8'(CHAR_MIN);
    localparam logic [7:0]        CODE_MAX  = 8'(CHAR_MAX);
    localparam logic [IDX_W-1:0]  SUBST_IDX = IDX_W'(SUBST_CHAR - CHAR_MIN);

    logic [COORD_W-1:0] w_dx;
    logic [COORD_W-1:0] w_dy;
    logic               w_win;
    logic [7:0]         w_code;
    logic               w_hide;
    logic [IDX_W-1:0]   w_idx;
    logic [ADDR_W-1:0]  w_addr;
    logic [23:0]        w_pal_rgb;

    logic [COORD_W-1:0] r_dx;
    logic [COORD_W-1:0] r_dy;
    logic [IDX_W-1:0]   r_idx;

    // Qualifier shift registers; index 0 is the stage-0 register, index
    // LAT-1 feeds the output register alongside rom_q.
    logic [LAT-1:0]     r_valid_sr;
    logic [LAT-1:0]     r_win_sr;
    logic [LAT-1:0]     r_hide_sr;
    logic [23:0]        r_fg_sr [LAT];
    logic [23:0]        r_bg_sr [LAT];

`ifdef GLYPH_BLINK_EN
    localparam int BCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BCNT_W-1:0] r_blink_cnt;
    logic              r_blink_hidden;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt    <= '0;
            r_blink_hidden <= 1'b0;
        end else if (frame_start) begin
            if (r_blink_cnt == BCNT_W'(BLINK_FRAMES - 1)) begin
                r_blink_cnt    <= '0;
                r_blink_hidden <= ~r_blink_hidden;
            end else begin
                r_blink_cnt <= r_blink_cnt + BCNT_W'(1);
            end
        end
    end

    assign w_code = {1'b0, char[6:0]};
    assign w_hide = char[7] & r_blink_hidden;
`else
    logic w_unused_frame_start;
    assign w_unused_frame_start = frame_start;
    assign w_code = char;
    assign w_hide = 1'b0;
`endif

    // Unsigned offsets: a scan position left of / above the origin wraps to a
    // large value and so falls outside the window without a signed compare.
    assign w_dx  = currentX - initialX;
    assign w_dy  = currentY - initialY;
    assign w_win = ({1'b0, w_dx} < WIN_W) && ({1'b0, w_dy} < WIN_H);
    assign w_idx = ((w_code >= CODE_MIN) && (w_code <= CODE_MAX)) ?
                   IDX_W'(w_code - CODE_MIN) : SUBST_IDX;

    assign w_addr = ADDR_W'(r_idx) * ADDR_W'(CELL)
                  + ADDR_W'(r_dy >> SCALE_LOG2) * ADDR_W'(GLYPH_W)
                  + ADDR_W'(r_dx >> SCALE_LOG2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dx       <= '0;
            r_dy       <= '0;
            r_idx      <= '0;
            r_valid_sr <= '0;
            r_win_sr   <= '0;
            r_hide_sr  <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_fg_sr[i] <= '0;
                r_bg_sr[i] <= '0;
            end
        end else begin
            r_dx       <= w_dx;
            r_dy       <= w_dy;
            r_idx      <= w_idx;
            r_valid_sr <= {r_valid_sr[LAT-2:0], pix_valid};
            r_win_sr   <= {r_win_sr[LAT-2:0], w_win};
            r_hide_sr  <= {r_hide_sr[LAT-2:0], w_hide};
            r_fg_sr[0] <= fg_rgb;
            r_bg_sr[0] <= bg_rgb;
            for (int i = 1; i < LAT; i++) begin
                r_fg_sr[i] <= r_fg_sr[i-1];
                r_bg_sr[i] <= r_bg_sr[i-1];
            end
        end
    end

    // Holding the address outside the window avoids needless ROM toggling.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr <= '0;
        end else if (r_win_sr[0]) begin
            rom_addr <= w_addr;
        end
    end

    glyph_palette u_palette (
        .i_idx    (color_idx_t'(rom_q)),
        .i_fg_rgb (r_fg_sr[LAT-1]),
        .i_bg_rgb (r_bg_sr[LAT-1]),
        .o_rgb    (w_pal_rgb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            RGB       <= '0;
            rgb_valid <= 1'b0;
            in_glyph  <= 1'b0;
        end else begin
            rgb_valid <= r_valid_sr[LAT-1];
            in_glyph  <= r_win_sr[LAT-1];
            if (!r_valid_sr[LAT-1] || !r_win_sr[LAT-1]) begin
                RGB <= '0;
            end else if (r_hide_sr[LAT-1]) begin
                RGB <= r_bg_sr[LAT-1];
            end else begin
                RGB <= w_pal_rgb;
            end
        end
    end

endmodule

// File: tb/tb_glyph_renderer.sv
`timescale 1ns/1ps
module tb_glyph_renderer;

    localparam int AW = 14;
    localparam int BF = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, pix_valid, frame_start;
    logic [7:0]  char;
    logic [23:0] fg_rgb, bg_rgb;
    logic [9:0]  initialX, initialY, currentX, currentY;

    logic [AW-1:0] a_addr, b_addr;
    logic [2:0]    a_q, b_q, b_q1;
    logic [23:0]   a_rgb, b_rgb;
    logic          a_v, b_v, a_g, b_g;

    glyph_renderer #(.BLINK_FRAMES(BF)) u_dut_a (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .frame_start(frame_start),
        .char(char), .fg_rgb(fg_rgb), .bg_rgb(bg_rgb),
        .initialX(initialX), .initialY(initialY), .currentX(currentX), .currentY(currentY),
        .rom_addr(a_addr), .rom_q(a_q), .RGB(a_rgb), .rgb_valid(a_v), .in_glyph(a_g)
    );

    glyph_renderer #(.SCALE_LOG2(1), .ROM_LAT(2), .BLINK_FRAMES(BF)) u_dut_b (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .frame_start(frame_start),
        .char(char), .fg_rgb(fg_rgb), .bg_rgb(bg_rgb),
        .initialX(initialX), .initialY(initialY), .currentX(currentX), .currentY(currentY),
        .rom_addr(b_addr), .rom_q(b_q), .RGB(b_rgb), .rgb_valid(b_v), .in_glyph(b_g)
    );

    function automatic logic [2:0] rom_f(input logic [AW-1:0] a);
        return 3'(a ^ (a >> 4));
    endfunction

    // Font ROM models: one-cycle for instance a, two-cycle for instance b
    always @(posedge clk) begin
        a_q  <= rom_f(a_addr);
        b_q1 <= rom_f(b_addr);
        b_q  <= b_q1;
    end

    function automatic logic [23:0] pal(input logic [2:0] i, input logic [23:0] fg,
                                        input logic [23:0] bg);
        case (i)
            3'd0:    return bg;
            3'd1:    return fg;
            3'd2:    return 24'hFF0000;
            3'd3:    return 24'h00FF00;
            3'd4:    return 24'h0000FF;
            3'd5:    return 24'hFFFF00;
            3'd6:    return 24'h00FFFF;
            default: return 24'hFFFFFF;
        endcase
    endfunction

    typedef struct {
        int          due;
        logic [23:0] rgb;
        logic        v;
        logic        g;
    } out_t;

    typedef struct {
        int          due;
        logic [AW-1:0] addr;
    } addr_t;

    out_t  qa_out[$], qb_out[$];
    addr_t qa_addr[$], qb_addr[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [AW-1:0] last_a = '0, last_b = '0;
`ifdef GLYPH_BLINK_EN
    int   m_cnt   = 0;
    logic m_phase = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic cmp_out(input string p, input out_t o, input logic [23:0] rgb,
                           input logic v, input logic g);
        chk({p, "_rgb"}, 32'(rgb), 32'(o.rgb));
        chk({p, "_valid"}, 32'(v), 32'(o.v));
        chk({p, "_in_glyph"}, 32'(g), 32'(o.g));
    endtask

    task automatic step();
        out_t  o;
        addr_t ad;
        @(posedge clk);
        cyc++;
        #1;
        if (qa_out.size() > 0 && qa_out[0].due == cyc) begin
            o = qa_out.pop_front();
            cmp_out("a", o, a_rgb, a_v, a_g);
        end
        if (qb_out.size() > 0 && qb_out[0].due == cyc) begin
            o = qb_out.pop_front();
            cmp_out("b", o, b_rgb, b_v, b_g);
        end
        if (qa_addr.size() > 0 && qa_addr[0].due == cyc) begin
            ad = qa_addr.pop_front();
            chk("a_rom_addr", 32'(a_addr), 32'(ad.addr));
        end
        if (qb_addr.size() > 0 && qb_addr[0].due == cyc) begin
            ad = qb_addr.pop_front();
            chk("b_rom_addr", 32'(b_addr), 32'(ad.addr));
        end
    endtask

    // Reference behaviour for one pixel sampled at the next edge.
    task automatic predict(input int scale, input int lat, inout logic [AW-1:0] last,
                           output out_t o, output addr_t ad);
        logic [9:0] dx, dy;
        logic       win, hide;
        int         code, idx;
        dx  = currentX - initialX;
        dy  = currentY - initialY;
        win = (int'(dx) < (8 << scale)) && (int'(dy) < (16 << scale));
`ifdef GLYPH_BLINK_EN
        code = int'(char[6:0]);
        hide = char[7] & m_phase;
`else
        code = int'(char);
        hide = 1'b0;
`endif
        idx = (code >= 32 && code <= 126) ? code - 32 : 63 - 32;
        if (rst) last = '0;
        else if (win) last = AW'(idx * 128 + (int'(dy) >> scale) * 8 + (int'(dx) >> scale));
        ad.due  = cyc + 2;
        ad.addr = last;
        o.due   = cyc + 1 + lat;
        if (rst) begin
            o.v = 1'b0; o.g = 1'b0; o.rgb = '0;
        end else begin
            o.v   = pix_valid;
            o.g   = win;
            o.rgb = (pix_valid && win) ?
                    (hide ? bg_rgb : pal(rom_f(last), fg_rgb, bg_rgb)) : 24'h0;
        end
    endtask

    // Everything still in flight when reset is sampled is flushed to zero.
    task automatic zero_pending();
        out_t  o;
        addr_t ad;
        for (int i = 0; i < qa_out.size(); i++) begin
            o = qa_out[i]; o.rgb = '0; o.v = 1'b0; o.g = 1'b0; qa_out[i] = o;
        end
        for (int i = 0; i < qb_out.size(); i++) begin
            o = qb_out[i]; o.rgb = '0; o.v = 1'b0; o.g = 1'b0; qb_out[i] = o;
        end
        for (int i = 0; i < qa_addr.size(); i++) begin
            ad = qa_addr[i]; ad.addr = '0; qa_addr[i] = ad;
        end
        for (int i = 0; i < qb_addr.size(); i++) begin
            ad = qb_addr[i]; ad.addr = '0; qb_addr[i] = ad;
        end
    endtask

    task automatic drive(input logic pv, input logic [9:0] x, input logic [9:0] y);
        out_t  o;
        addr_t ad;
        pix_valid = pv;
        currentX  = x;
        currentY  = y;
        if (rst) zero_pending();
        predict(0, 3, last_a, o, ad);
        qa_out.push_back(o);
        qa_addr.push_back(ad);
        predict(1, 4, last_b, o, ad);
        qb_out.push_back(o);
        qb_addr.push_back(ad);
`ifdef GLYPH_BLINK_EN
        if (rst) begin
            m_cnt = 0; m_phase = 1'b0;
        end else if (frame_start) begin
            if (m_cnt == BF - 1) begin
                m_cnt = 0; m_phase = ~m_phase;
            end else begin
                m_cnt++;
            end
        end
`endif
        step();
    endtask

    task automatic chk_all_zero(input string p);
        chk({p, "_a_rgb"}, 32'(a_rgb), 32'h0);
        chk({p, "_a_valid"}, 32'(a_v), 32'h0);
        chk({p, "_a_in_glyph"}, 32'(a_g), 32'h0);
        chk({p, "_a_rom_addr"}, 32'(a_addr), 32'h0);
        chk({p, "_b_rgb"}, 32'(b_rgb), 32'h0);
        chk({p, "_b_rom_addr"}, 32'(b_addr), 32'h0);
    endtask

    logic [7:0] chars_tbl [7];
    logic [9:0] rows_tbl  [5];

    initial begin
        chars_tbl = '{8'd10, 8'd127, 8'd200, 8'd32, 8'd126, 8'd65, 8'd0};
        rows_tbl  = '{10'd49, 10'd50, 10'd65, 10'd66, 10'd81};

        rst = 1'b1; frame_start = 1'b0; pix_valid = 1'b0;
        char = 8'd65; fg_rgb = 24'h123456; bg_rgb = 24'hABCDEF;
        initialX = 10'd100; initialY = 10'd50; currentX = '0; currentY = '0;
        repeat (3) drive(1'b0, 10'd0, 10'd0);
        chk_all_zero("reset");
        rst = 1'b0;

        // horizontal scan across 'A' including both edges
        for (int x = 95; x <= 110; x++) drive(1'b1, 10'(x), 10'd50);
        for (int i = 0; i < 5; i++) drive(1'b1, 10'd105, rows_tbl[i]);

        // out-of-range and boundary codes
        for (int i = 0; i < 7; i++) begin
            char = chars_tbl[i];
            drive(1'b1, 10'd100, 10'd50);
            drive(1'b1, 10'd103, 10'd52);
        end
        char = 8'd65;

        // wrap-around to the left of / above the origin
        drive(1'b1, 10'd5, 10'd50);
        drive(1'b1, 10'd100, 10'd3);

        // origin at zero exercises the scaled window edges
        initialX = 10'd0; initialY = 10'd0;
        for (int x = 0; x <= 17; x++) drive(1'b1, 10'(x), 10'd0);
        drive(1'b1, 10'd0, 10'd15);
        drive(1'b1, 10'd0, 10'd16);
        drive(1'b1, 10'd15, 10'd31);
        drive(1'b1, 10'd0, 10'd32);

        // per-pixel attribute changes
        for (int i = 0; i < 300; i++) begin
            char        = 8'($urandom_range(0, 255));
            fg_rgb      = 24'($urandom);
            bg_rgb      = 24'($urandom);
            initialX    = 10'($urandom_range(90, 110));
            initialY    = 10'($urandom_range(40, 60));
            frame_start = ($urandom_range(0, 15) == 0);
            drive(($urandom_range(0, 3) != 0), 10'($urandom_range(80, 130)),
                  10'($urandom_range(30, 100)));
        end
        frame_start = 1'b0;

        // reset in the middle of an active line, coincident with frame_start
        char = 8'd65; fg_rgb = 24'h00AA55; bg_rgb = 24'h331100;
        initialX = 10'd100; initialY = 10'd50;
        for (int x = 100; x <= 103; x++) drive(1'b1, 10'(x), 10'd50);
        rst = 1'b1; frame_start = 1'b1;
        drive(1'b1, 10'd104, 10'd50);
        chk_all_zero("midrst");
        rst = 1'b0; frame_start = 1'b0;
        for (int x = 105; x <= 108; x++) drive(1'b1, 10'(x), 10'd50);

        // blinking glyph over five frames; dx=1,dy=0 reads ROM index 1
        char = 8'h80 | 8'd65;
        for (int f = 0; f <= 4; f++) begin
            repeat (2) drive(1'b1, 10'd101, 10'd50);
            frame_start = 1'b1;
            drive(1'b0, 10'd0, 10'd0);
            frame_start = 1'b0;
        end
        repeat (2) drive(1'b1, 10'd101, 10'd50);

        repeat (6) step();
        chk("drain_a", 32'(qa_out.size() + qa_addr.size()), 32'h0);
        chk("drain_b", 32'(qb_out.size() + qb_addr.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/glyph_renderer.md
# glyph_renderer

Pipelined, parametrised character-cell renderer for the VGA text path. It draws one glyph from a single shared font ROM at a programmable screen origin, with optional integer scaling. It replaces the per-character ROM bank and mux with one address computation. It aligns the window/valid qualifiers to the ROM read latency and colours pixels through a foreground/background palette. It sits between the VGA timing generator (current pixel coordinates) and the pixel mixer.

## Interface
Parameters:
- GLYPH_W, 8: glyph width in font pixels.
- GLYPH_H, 16: glyph height in font pixels.
- SCALE_LOG2, 0: on-screen magnification, 2^SCALE_LOG2 in both axes (0..2).
- CHAR_MIN, 32: first code stored in the ROM.
- CHAR_MAX, 126: last code stored in the ROM.
- SUBST_CHAR, 63: code drawn for out-of-range chars ('?').
- ROM_LAT, 1: font ROM read latency in cycles (1..2).
- BLINK_FRAMES, 30: frames per blink half-period.

Derived: ADDR_W = clog2((CHAR_MAX-CHAR_MIN+1)*GLYPH_W*GLYPH_H); LAT = ROM_LAT+2.

Ports:
- clk, in, 1: pixel clock.
- rst, in, 1: synchronous, active-high reset.
- pix_valid, in, 1: currentX/currentY denote an active-area pixel.
- frame_start, in, 1: one-cycle pulse per frame.
- char, in, 8: character code.
- fg_rgb, in, 24: colour for index 1.
- bg_rgb, in, 24: colour for index 0.
- initialX, in, 10: glyph origin X.
- initialY, in, 10: glyph origin Y.
- currentX, in, 10: scan X.
- currentY, in, 10: scan Y.
- rom_addr, out, ADDR_W: registered font ROM address.
- rom_q, in, 3: colour index returned by the ROM.
- RGB, out, 24: pixel colour.
- rgb_valid, out, 1: pix_valid delayed by LAT.
- in_glyph, out, 1: pixel lies inside the glyph window, delayed by LAT.

## Operation
- Stage 0 registers the following:
  - dx = currentX-initialX and dy = currentY-initialY, unsigned 10-bit; wrap-around yields large values, which fall outside the window.
  - win = dx < (GLYPH_W<<SCALE_LOG2) && dy < (GLYPH_H<<SCALE_LOG2).
  - The glyph index.
- Glyph index: char-CHAR_MIN when CHAR_MIN ≤ char ≤ CHAR_MAX, otherwise SUBST_CHAR-CHAR_MIN.
- Stage 1 registers rom_addr = idx*GLYPH_W*GLYPH_H + (dy>>SCALE_LOG2)*GLYPH_W + (dx>>SCALE_LOG2).
  - Outside the window, rom_addr holds its previous value.
- win, pix_valid and the blink qualifier travel in a shift register of depth LAT.
- Palette, applied at the output register:
  - rom_q 0 → bg_rgb; 1 → fg_rgb.
  - 2..7 → fixed constants: red, green, blue, yellow, cyan, white.
- Output register:
  - rgb_valid=0 or in_glyph=0 → RGB = 24'h000000.
  - Otherwise → palette colour.
- Inputs may change on any cycle. Each pixel is processed with the char, fg/bg and origin sampled in its own stage 0.

## Timing
- Pixel presented at cycle t appears on RGB/rgb_valid/in_glyph at t+LAT. Throughput is one pixel per cycle with no stalls.
- Reset values:
  - RGB=0, rgb_valid=0, in_glyph=0, rom_addr=0.
  - Qualifier pipeline cleared.
  - Blink counter=0, blink phase=visible.
- Reset mid-frame: outputs go to 0 at the next edge. The first valid output follows LAT cycles after the first post-reset pix_valid.
- rst and frame_start in the same cycle: rst wins.
- Boundary pixels:
  - dx = (GLYPH_W<<SCALE_LOG2)-1 is inside the window.
  - dx = GLYPH_W<<SCALE_LOG2 is outside.

## Configuration
- GLYPH_BLINK_EN defined:
  - char[7]=1 marks a blinking glyph; the code is char[6:0].
  - A counter of frame_start pulses toggles the blink phase every BLINK_FRAMES frames.
  - In the hidden phase, blinking glyph pixels output bg_rgb; in_glyph stays 1.
- GLYPH_BLINK_EN undefined:
  - The full 8-bit char is the code, so codes ≥128 draw SUBST_CHAR.
  - frame_start is ignored and no counter is synthesised.

## Structure
- Package glyph_pkg holds:
  - The color index typedef (3-bit).
  - The palette constants for indices 2..7.
  - The window/offset width constant (10).
- Sub-module glyph_palette: combinational index→24-bit RGB decoder taking fg_rgb/bg_rgb. The registered output lives in glyph_renderer.

## Test plan
- Origin (100,50), char 'A'(65), defaults, ROM_LAT=1, scan currentX 100..107 at Y=50 → rom_addr 33*128+0..7 at t+1; rgb_valid/in_glyph=1 at t+3, colours per ROM.
- currentX=99 or 108, Y=50 → in_glyph=0, RGB=0; currentX=5 with initialX=100 (wrap) → outside.
- char=10 and char=127 → rom_addr base 31*128 (substitution '?').
- SCALE_LOG2=1, origin (0,0), currentX 0,1 → same rom_addr; window ends at dx=16, dy=32.
- GLYPH_BLINK_EN, BLINK_FRAMES=2, char=0x80|65, ROM index 1 pixel → fg_rgb for frames 0–1, bg_rgb for frames 2–3, fg again at frame 4.
- Assert rst during an active line → all outputs 0 next edge. frame_start with rst → blink counter stays 0.
